// File: rtl/hop_sched_pkg.sv
// Shared definitions for the hop-lane scheduler: FSM states, default sizing
// and the per-lane timer width.
package hop_sched_pkg;

    localparam int LANES_DEF = 4;
    localparam int DEPTH_DEF = 6;
    localparam int NRST_DEF  = 20;

    function automatic int tmr_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int TMR_W = tmr_width(DEPTH_DEF);

    typedef enum logic [1:0] {
        HOLD,
        RELEASE,
        RUN,
        FLUSH
    } state_t;

endpackage

// File: rtl/hop_rr_arb.sv
// Combinational round-robin arbiter: picks the first requester at or after
// the pointer and returns the pointer value one past the winner.
module hop_rr_arb #(
    parameter int LANES = 4,
    parameter int PW    = 2
) (
    input  logic [LANES-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [LANES-1:0] grant,
    output logic [PW-1:0]    next_ptr
);

    // Scan lanes starting at the pointer; the pointer holds when nobody asks.
    always_comb begin
        logic          found;
        logic [PW-1:0] idx;
        grant    = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = '0;
        for (int off = 0; off < LANES; off++) begin
            idx = PW'((int'(ptr) + off) % LANES);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                next_ptr   = PW'((int'(idx) + 1) % LANES);
            end
        end
    end

endmodule

// File: rtl/hop_lane_sched.sv
// Hop-lane scheduler: sequences per-stage reset release, then round-robin
// launches tokens into single-bit lanes and checks their arrival at the tail.
module hop_lane_sched
    import hop_sched_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int NRST  = NRST_DEF
) (
    input  logic             clock0,
    input  logic             rst_n,
    input  logic [LANES-1:0] req,
    input  logic             flush,
    input  logic [LANES-1:0] lane_out,
    output logic [LANES-1:0] gnt,
    output logic [LANES-1:0] start,
    output logic [NRST-1:0]  stage_rst,
    output logic [LANES-1:0] busy,
    output logic [LANES-1:0] done,
    output logic [LANES-1:0] err,
    output logic             ready
);

    localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int TW = (DEPTH == DEPTH_DEF) ? TMR_W : tmr_width(DEPTH);
    localparam int RW = $clog2(NRST + 1);

    state_t           state;
    logic [RW-1:0]    rcnt;
    logic             fcnt;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    next_ptr;
    logic [LANES-1:0] eligible;
    logic [LANES-1:0] arb_gnt;
    logic [TW-1:0]    tmr [LANES];

    assign eligible = req & ~busy;

    hop_rr_arb #(
        .LANES (LANES),
        .PW    (PW)
    ) u_arb (
        .req      (eligible),
        .ptr      (ptr),
        .grant    (arb_gnt),
        .next_ptr (next_ptr)
    );

    // Control FSM plus all registered outputs and per-lane token timers.
    // The timer reads 0 in the start cycle, so done fires as it passes DEPTH-1.
    always_ff @(posedge clock0 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HOLD;
            rcnt      <= '0;
            fcnt      <= 1'b0;
            ptr       <= '0;
            stage_rst <= '1;
            gnt       <= '0;
            start     <= '0;
            busy      <= '0;
            done      <= '0;
            err       <= '0;
            ready     <= 1'b0;
            for (int i = 0; i < LANES; i++) tmr[i] <= '0;
        end else begin
            gnt   <= '0;
            start <= '0;
            done  <= '0;
            ready <= 1'b0;
            err   <= err | (done & ~lane_out);
            if (flush && state != HOLD) begin
                // Flush wins over any grant; err and the pointer survive.
                state     <= FLUSH;
                fcnt      <= 1'b0;
                rcnt      <= '0;
                stage_rst <= '1;
                busy      <= '0;
                for (int i = 0; i < LANES; i++) tmr[i] <= '0;
            end else begin
                case (state)
                    HOLD: begin
                        state <= RELEASE;
                        rcnt  <= '0;
                    end
                    RELEASE: begin
                        if (rcnt == RW'(NRST)) begin
                            state <= RUN;
                            ready <= 1'b1;
                        end else begin
                            stage_rst[rcnt] <= 1'b0;
                            rcnt            <= rcnt + RW'(1);
                        end
                    end
                    RUN: begin
                        ready <= 1'b1;
                        gnt   <= arb_gnt;
                        start <= arb_gnt;
                        ptr   <= next_ptr;
                        for (int i = 0; i < LANES; i++) begin
                            if (arb_gnt[i]) begin
                                busy[i] <= 1'b1;
                                tmr[i]  <= '0;
                            end else if (busy[i]) begin
                                if (done[i]) begin
                                    busy[i] <= 1'b0;
                                    tmr[i]  <= '0;
                                end else begin
                                    if (tmr[i] < TW'(DEPTH)) tmr[i] <= tmr[i] + TW'(1);
                                    if (tmr[i] == TW'(DEPTH - 1)) done[i] <= 1'b1;
                                end
                            end
                        end
                    end
                    FLUSH: begin
                        if (fcnt) begin
                            state <= RELEASE;
                            rcnt  <= '0;
                        end else begin
                            fcnt <= 1'b1;
                        end
                    end
                    default: state <= HOLD;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hop_lane_sched.sv
// Scoreboard bench for hop_lane_sched: directed requests push expected grant
// and done events; a negedge monitor pops and compares them.
module tb_hop_lane_sched;

    localparam int LANES = 4;
    localparam int DEPTH = 6;
    localparam int NRST  = 20;

    logic             clock0 = 1'b0;
    logic             rst_n  = 1'b0;
    logic [LANES-1:0] req    = '0;
    logic             flush  = 1'b0;
    logic [LANES-1:0] lane_out;
    logic [LANES-1:0] gnt, start, busy, done, err;
    logic [NRST-1:0]  stage_rst;
    logic             ready;

    typedef struct {
        int lane;
        int cycle;
    } ev_t;

    ev_t gnt_q[$];
    ev_t done_q[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;

    logic [DEPTH-1:0] shreg [LANES];
    logic [LANES-1:0] kill = '0;

    always #5 clock0 = ~clock0;

    always @(posedge clock0) cyc <= cyc + 1;

    // Lane models: each lane echoes start DEPTH cycles later unless killed.
    always @(posedge clock0) begin
        for (int i = 0; i < LANES; i++) shreg[i] <= {shreg[i][DEPTH-2:0], start[i]};
    end

    always_comb begin
        lane_out = '0;
        for (int i = 0; i < LANES; i++) lane_out[i] = shreg[i][DEPTH-1] & ~kill[i];
    end

    hop_lane_sched #(
        .LANES (LANES),
        .DEPTH (DEPTH),
        .NRST  (NRST)
    ) dut (
        .clock0    (clock0),
        .rst_n     (rst_n),
        .req       (req),
        .flush     (flush),
        .lane_out  (lane_out),
        .gnt       (gnt),
        .start     (start),
        .stage_rst (stage_rst),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .ready     (ready)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [LANES-1:0] r, input logic f);
        req   = r;
        flush = f;
    endtask

    // Requesters drop their request once they see their grant.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clock0);
            req = req & ~gnt;
        end
    endtask

    task automatic expectGnt(input int lane, input int cycle);
        ev_t e;
        e.lane  = lane;
        e.cycle = cycle;
        gnt_q.push_back(e);
    endtask

    task automatic expectDone(input int lane, input int cycle);
        ev_t e;
        e.lane  = lane;
        e.cycle = cycle;
        done_q.push_back(e);
    endtask

    function automatic logic [31:0] relMask(input int j);
        logic [31:0] m;
        m = 32'h000F_FFFF;
        return (m << ((j > NRST) ? NRST : j)) & 32'h000F_FFFF;
    endfunction

    // Walk the release sequence starting in the first release cycle.
    task automatic checkRelease();
        for (int j = 0; j <= NRST + 1; j++) begin
            tick(1);
            checkOutput("release_stage", 32'(stage_rst), relMask(j));
            checkOutput("release_ready", 32'(ready), 32'((j >= NRST + 1) ? 1 : 0));
        end
    endtask

    always @(negedge clock0) begin
        ev_t e;
        if (gnt !== '0) begin
            if (gnt_q.size() == 0) begin
                checkOutput("unexpected_gnt", 32'(gnt), 32'h0);
            end else begin
                e = gnt_q.pop_front();
                checkOutput("gnt_lane", 32'(gnt), 32'(1 << e.lane));
                checkOutput("start_lane", 32'(start), 32'(1 << e.lane));
                checkOutput("gnt_cycle", 32'(cyc), 32'(e.cycle));
            end
        end
        if (done !== '0) begin
            if (done_q.size() == 0) begin
                checkOutput("unexpected_done", 32'(done), 32'h0);
            end else begin
                e = done_q.pop_front();
                checkOutput("done_lane", 32'(done), 32'(1 << e.lane));
                checkOutput("done_cycle", 32'(cyc), 32'(e.cycle));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog cycle=%0d got=running want=finished", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r, t, u, v, w, x;

        tick(2);
        checkOutput("rst_stage", 32'(stage_rst), 32'h000F_FFFF);
        checkOutput("rst_outs", 32'({gnt, start, busy, done, err, ready}), 32'h0);

        rst_n = 1'b1;
        checkRelease();

        // All four lanes request together.
        r = cyc;
        applyStimulus(4'b1111, 1'b0);
        for (int i = 0; i < LANES; i++) begin
            expectGnt(i, r + 1 + i);
            expectDone(i, r + 1 + i + DEPTH);
        end
        tick(12);
        checkOutput("rr_err", 32'(err), 32'h0);
        checkOutput("rr_idle", 32'(busy), 32'h0);

        // Lane 2 busy while requesting again; lane 0 goes first.
        t = cyc;
        applyStimulus(4'b0100, 1'b0);
        expectGnt(2, t + 1);
        tick(2);
        applyStimulus(4'b0101, 1'b0);
        expectGnt(0, t + 3);
        expectGnt(2, t + 9);
        expectDone(2, t + 7);
        expectDone(0, t + 9);
        expectDone(2, t + 15);
        tick(6);
        checkOutput("skip_busy", 32'(busy), 32'h1);
        tick(8);

        // Lane 1 loses its token.
        u = cyc;
        kill = 4'b0010;
        applyStimulus(4'b0010, 1'b0);
        expectGnt(1, u + 1);
        expectDone(1, u + 7);
        tick(7);
        checkOutput("miss_err_pre", 32'(err), 32'h0);
        tick(1);
        checkOutput("miss_err", 32'(err), 32'h2);
        tick(1);

        // Flush two cycles after a grant on lane 3, with a competing request.
        v = cyc;
        applyStimulus(4'b1000, 1'b0);
        expectGnt(3, v + 1);
        tick(3);
        applyStimulus(4'b0001, 1'b1);
        expectGnt(0, v + 28);
        expectDone(0, v + 34);
        tick(1);
        flush = 1'b0;
        checkOutput("flush_busy", 32'(busy), 32'h0);
        checkOutput("flush_stage0", 32'(stage_rst), 32'h000F_FFFF);
        checkOutput("flush_ready", 32'(ready), 32'h0);
        tick(1);
        checkOutput("flush_stage1", 32'(stage_rst), 32'h000F_FFFF);
        checkRelease();
        checkOutput("err_sticky", 32'(err), 32'h2);
        tick(9);

        // Asynchronous reset with all lanes in flight.
        w = cyc;
        applyStimulus(4'b1111, 1'b0);
        expectGnt(1, w + 1);
        expectGnt(2, w + 2);
        expectGnt(3, w + 3);
        expectGnt(0, w + 4);
        tick(5);
        checkOutput("all_busy", 32'(busy), 32'hF);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_stage", 32'(stage_rst), 32'h000F_FFFF);
        checkOutput("async_outs", 32'({gnt, start, busy, done, err, ready}), 32'h0);
        tick(10);

        // Pointer restarts at lane 0 after reset.
        kill = '0;
        rst_n = 1'b1;
        checkRelease();
        x = cyc;
        applyStimulus(4'b1001, 1'b0);
        expectGnt(0, x + 1);
        expectGnt(3, x + 2);
        expectDone(0, x + 7);
        expectDone(3, x + 8);
        tick(10);

        checkOutput("gnt_q_empty", 32'(gnt_q.size()), 32'h0);
        checkOutput("done_q_empty", 32'(done_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hop_lane_sched.md
HOP_LANE_SCHED -- requirements
Module: hop_lane_sched

Interface
REQ-001 Parameter LANES, default 4: number of hop lanes, each a single-bit register chain.
REQ-002 Parameter DEPTH, default 6: register stages per lane, start input to lane tail.
REQ-003 Parameter NRST, default 20: number of per-stage reset outputs.
REQ-004 Port clock0  input  1: sole clock; all logic on its rising edge.
REQ-005 Port rst_n  input  1: asynchronous active-low reset for all block state.
REQ-006 Port req  input  LANES: per-lane launch request; held by requester until gnt.
REQ-007 Port flush  input  1: synchronous request to re-reset all lanes and re-run the release sequence.
REQ-008 Port lane_out  input  LANES: tail register value of each lane.
REQ-009 Port gnt  output  LANES: one-hot, one-cycle grant pulse.
REQ-010 Port start  output  LANES: registered launch pulse to lane head; equals gnt.
REQ-011 Port stage_rst  output  NRST: active-high per-stage resets to the lanes.
REQ-012 Port busy  output  LANES: lane holds an in-flight token.
REQ-013 Port done  output  LANES: one-cycle pulse when a token is due at the lane tail.
REQ-014 Port err  output  LANES: sticky; token missing at the lane tail when due.
REQ-015 Port ready  output  1: high only in state RUN.

Function
REQ-016 The FSM SHALL have states HOLD, RELEASE, RUN, FLUSH.
REQ-017 HOLD: all stage_rst high; advance to RELEASE on the first clock after reset deassertion.
REQ-018 RELEASE: deassert stage_rst[k] in the k-th RELEASE cycle, k = 0..NRST-1, lowest index first; enter RUN the cycle after stage_rst[NRST-1] drops.
REQ-019 RUN: each cycle, round-robin arbitration over req & ~busy; at most one grant per cycle.
REQ-020 Arbitration: the pointer starts at lane 0 and advances to one past the last granted lane; it is unchanged when nothing is granted.
REQ-021 Grant timing: req sampled at edge k gives gnt[i], start[i] and busy[i] high in cycle k+1.
REQ-022 Per-lane timer: counts DEPTH cycles from the start cycle; done[i] is high exactly in cycle start+DEPTH.
REQ-023 At the done cycle, lane_out[i]==0 SHALL set err[i]; err clears only on rst_n.
REQ-024 busy[i] SHALL clear in the cycle after done[i]; the lane is grantable again on that cycle's edge.
REQ-025 A requesting lane that is busy SHALL be skipped without affecting the pointer.
REQ-026 flush in any state except HOLD: the next cycle enters FLUSH, drives all stage_rst high, and clears busy, timers, and in-flight done.
REQ-027 FLUSH SHALL last exactly 2 cycles, then go to RELEASE; err and the arbitration pointer are kept.
REQ-028 flush asserted during RELEASE SHALL restart the sequence from index 0 via FLUSH.
REQ-029 Outside RUN: gnt, start and done SHALL be 0, and req is ignored.
REQ-030 flush and a grant-eligible req in the same RUN cycle: flush wins, and no grant is issued.

Reset
REQ-031 While rst_n is low, the block SHALL be in HOLD with stage_rst all 1, and gnt, start, busy, done, err and ready all 0, and the pointer = 0.
REQ-032 Reset assertion mid-operation SHALL abandon all in-flight tokens immediately, with no done pulse.

Structure
REQ-033 Package hop_sched_pkg SHALL hold the FSM state enum, the LANES/DEPTH/NRST defaults, and the timer width constant $clog2(DEPTH+1).
REQ-034 The round-robin arbiter SHALL be a sub-module hop_rr_arb with inputs req vector and pointer, and outputs one-hot grant and next pointer.

Verification
REQ-035 Release after reset: rst_n rises at cycle 0 -> stage_rst[k] falls at cycle 2+k, and ready is high from cycle 22.
REQ-036 Round-robin: req=4'b1111 held in RUN, lane models echo start after 6 cycles -> grants 0,1,2,3 on consecutive cycles, done 6 cycles after each grant, err=0.
REQ-037 Busy skip: lane 2 in flight and req=4'b0100|4'b0001 -> lane 0 granted, lane 2 granted on the cycle after its busy clears.
REQ-038 Missing token: lane model for lane 1 forced to 0 -> done[1] at start+6 and err[1]=1, which stays set after flush.
REQ-039 Flush mid-flight: flush 2 cycles after a grant on lane 3 -> no done[3], busy[3]=0, stage_rst all high for 2 cycles, then a 20-cycle release, then ready.
REQ-040 Async reset during RUN with 4 lanes busy -> all outputs take their REQ-031 values without a clock edge.
